mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly downstream of the execute functional unit. Accepts one `MEM_REQUIRE` per handshake, performs at most one word load or store on the data-memory request/grant/response port, and presents a registered `WB_REQUIRE` to writeback plus a forwarding tap. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_out_reg.sv | 40 ++++
 rtl/mem_stage.sv | 117 +++++++++++
 tb/tb_mem_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: request/writeback records and FSM states.
package mem_stage_pkg;

  typedef struct packed {
    logic        mem_read_ena;
    logic        mem_write_ena;
    logic        write_reg_need;
    logic [4:0]  write_reg_addr;
    logic [31:0] result;
    logic [31:0] write_data;
    logic [31:0] addr;
  } MEM_REQUIRE;

  typedef struct packed {
    logic        write_reg_need;
    logic [4:0]  write_reg_addr;
    logic [31:0] write_data;
  } WB_REQUIRE;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} MEM_STATE;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_out_reg.sv
// Writeback holding register with valid/ready handshake and the forwarding tap decode.
module mem_out_reg
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  WB_REQUIRE   load_data_i,
  input  logic        out_ready_i,
  output logic        out_valid_o,
  output WB_REQUIRE   wb_o,
  output logic        fwd_valid_o,
  output logic [4:0]  fwd_addr_o,
  output logic [31:0] fwd_data_o
);

  logic      valid_q;
  WB_REQUIRE data_q;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
    end else if (valid_q && out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign wb_o        = data_q;
  // r0 is hardwired zero, so it is never a forwarding source.
  assign fwd_valid_o = valid_q && data_q.write_reg_need && (data_q.write_reg_addr != 5'd0);
  assign fwd_addr_o  = data_q.write_reg_addr;
  assign fwd_data_o  = data_q.write_data;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one load/store per accepted request, registered writeback output.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  MEM_REQUIRE  mem_require,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output WB_REQUIRE   wb_require,
  output logic        addr_err,
  output logic        fwd_valid,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data
);

  MEM_STATE   state_q, state_d;
  MEM_REQUIRE req_q, req_d;
  logic       addr_err_q, addr_err_d;
  logic       accept, in_is_mem, req_is_load;
  logic       wb_load;
  WB_REQUIRE  wb_load_data;

  assign in_is_mem   = mem_require.mem_read_ena | mem_require.mem_write_ena;
  assign in_ready    = (state_q == IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  // A request with both enables set is treated as a load.
  assign req_is_load = req_q.mem_read_ena;

  assign req_d      = accept ? mem_require : req_q;
  assign addr_err_d = accept && in_is_mem &&
                      ((mem_require.addr[1:0] != 2'b00) ||
                       (mem_require.mem_read_ena && mem_require.mem_write_ena));

  // NOTE: the input register is reset too, so the dmem_* buses read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_err_q <= addr_err_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && in_is_mem) state_d = REQ;
      REQ:     if (dmem_gnt) state_d = req_is_load ? WAIT : IDLE;
      WAIT:    if (dmem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_req     = 1'b0;
    wb_load      = 1'b0;
    wb_load_data = '0;
    unique case (state_q)
      IDLE: begin
        if (accept && !in_is_mem) begin
          wb_load      = 1'b1;
          wb_load_data = '{mem_require.write_reg_need, mem_require.write_reg_addr,
                           mem_require.result};
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt && !req_is_load) begin
          wb_load      = 1'b1;
          wb_load_data = '{1'b0, req_q.write_reg_addr, req_q.result};
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          wb_load      = 1'b1;
          wb_load_data = '{req_q.write_reg_need, req_q.write_reg_addr, dmem_rdata};
        end
      end
      default: ;
    endcase
  end

  // Address, data and direction come straight from the input register, which only
  // changes on accept, so they stay stable for the whole REQ phase.
  assign dmem_we    = req_q.mem_write_ena && !req_q.mem_read_ena;
  assign dmem_addr  = req_q.addr & WORD_MASK;
  assign dmem_wdata = req_q.write_data;
  assign addr_err   = addr_err_q;

  mem_out_reg u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (wb_load),
    .load_data_i (wb_load_data),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .wb_o        (wb_require),
    .fwd_valid_o (fwd_valid),
    .fwd_addr_o  (fwd_addr),
    .fwd_data_o  (fwd_data)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of non-memory ops plus load/store/backpressure/reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  MEM_REQUIRE  mreq;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        out_valid, out_ready, addr_err, fwd_valid;
  WB_REQUIRE   wb_require;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;

  mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mem_require(mreq),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .wb_require(wb_require),
    .addr_err(addr_err), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        need;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        exp_fwd;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic MEM_REQUIRE mk(input logic rd_en, input logic wr_en, input logic need,
                                    input logic [4:0] ra, input logic [31:0] res,
                                    input logic [31:0] wd, input logic [31:0] ad);
    MEM_REQUIRE m;
    m.mem_read_ena   = rd_en;
    m.mem_write_ena  = wr_en;
    m.write_reg_need = need;
    m.write_reg_addr = ra;
    m.result         = res;
    m.write_data     = wd;
    m.addr           = ad;
    return m;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b1};
    vecs[1] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{1'b1, 5'd0,  32'h0000_0007, 1'b0};
    vecs[3] = '{1'b0, 5'd12, 32'h0000_CAFE, 1'b0};
    vecs[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1};

    rst = 1'b1; in_valid = 1'b0; mreq = '0; out_ready = 1'b1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    tick(); tick();
    check_bit("rst out_valid", out_valid, 1'b0);
    check("rst wb_require", 32'(wb_require), 32'd0);
    check_bit("rst dmem_req", dmem_req, 1'b0);
    check_bit("rst dmem_we", dmem_we, 1'b0);
    check("rst dmem_addr", dmem_addr, 32'd0);
    check("rst dmem_wdata", dmem_wdata, 32'd0);
    check_bit("rst addr_err", addr_err, 1'b0);
    check_bit("rst fwd_valid", fwd_valid, 1'b0);
    rst = 1'b0;
    #1;
    check_bit("idle in_ready", in_ready, 1'b1);

    // Back-to-back non-memory ops, one per cycle.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      mreq = mk(1'b0, 1'b0, vecs[i].need, vecs[i].rd, vecs[i].result, 32'h5555_0000, 32'h0000_0100);
      #1;
      check_bit($sformatf("v%0d in_ready", i), in_ready, 1'b1);
      tick();
      check_bit($sformatf("v%0d out_valid", i), out_valid, 1'b1);
      check_bit($sformatf("v%0d need", i), wb_require.write_reg_need, vecs[i].need);
      check($sformatf("v%0d rd", i), 32'(wb_require.write_reg_addr), 32'(vecs[i].rd));
      check($sformatf("v%0d data", i), wb_require.write_data, vecs[i].result);
      check_bit($sformatf("v%0d fwd_valid", i), fwd_valid, vecs[i].exp_fwd);
      check_bit($sformatf("v%0d dmem_req", i), dmem_req, 1'b0);
    end
    check("fwd_addr", 32'(fwd_addr), 32'd1);
    check("fwd_data", fwd_data, 32'd0);
    in_valid = 1'b0;
    tick();
    check_bit("drain out_valid", out_valid, 1'b0);

    // Load at 0x100, grant after two wait cycles, data one cycle after grant.
    in_valid = 1'b1;
    mreq = mk(1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 32'h0, 32'h0000_0100);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_bit($sformatf("ld req c%0d", c), dmem_req, 1'b1);
      check($sformatf("ld addr c%0d", c), dmem_addr, 32'h0000_0100);
      check_bit($sformatf("ld we c%0d", c), dmem_we, 1'b0);
      check_bit($sformatf("ld in_ready c%0d", c), in_ready, 1'b0);
      check_bit($sformatf("ld out_valid c%0d", c), out_valid, 1'b0);
      if (c == 0) check_bit("ld addr_err", addr_err, 1'b0);
      if (c == 2) dmem_gnt = 1'b1;
      tick();
    end
    dmem_gnt = 1'b0;
    check_bit("ld wait req", dmem_req, 1'b0);
    check_bit("ld wait out_valid", out_valid, 1'b0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    check_bit("ld out_valid N+5", out_valid, 1'b1);
    check("ld data", wb_require.write_data, 32'hDEAD_BEEF);
    check("ld rd", 32'(wb_require.write_reg_addr), 32'd7);
    check_bit("ld fwd_valid", fwd_valid, 1'b1);
    tick();
    check_bit("ld drained", out_valid, 1'b0);

    // Stray grant/response in IDLE must be ignored.
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    check_bit("idle stray out_valid", out_valid, 1'b0);
    check_bit("idle stray dmem_req", dmem_req, 1'b0);

    // Misaligned store, immediate grant.
    in_valid = 1'b1;
    mreq = mk(1'b0, 1'b1, 1'b1, 5'd9, 32'h0, 32'hA5A5_A5A5, 32'h0000_0203);
    tick();
    in_valid = 1'b0;
    check_bit("st req", dmem_req, 1'b1);
    check("st addr", dmem_addr, 32'h0000_0200);
    check_bit("st we", dmem_we, 1'b1);
    check("st wdata", dmem_wdata, 32'hA5A5_A5A5);
    check_bit("st addr_err", addr_err, 1'b1);
    check_bit("st in_ready", in_ready, 1'b0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check_bit("st out_valid N+2", out_valid, 1'b1);
    check_bit("st need", wb_require.write_reg_need, 1'b0);
    check_bit("st fwd_valid", fwd_valid, 1'b0);
    check_bit("st addr_err pulse end", addr_err, 1'b0);
    check_bit("st req done", dmem_req, 1'b0);
    tick();

    // Both enables: load wins, store suppressed, addr_err flagged.
    in_valid = 1'b1;
    mreq = mk(1'b1, 1'b1, 1'b1, 5'd3, 32'h0, 32'h9999_9999, 32'h0000_0010);
    tick();
    in_valid = 1'b0;
    check_bit("both we", dmem_we, 1'b0);
    check_bit("both addr_err", addr_err, 1'b1);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0055;
    tick();
    dmem_rvalid = 1'b0;
    check_bit("both out_valid", out_valid, 1'b1);
    check("both data", wb_require.write_data, 32'h0000_0055);
    tick();

    // Backpressure: output held four cycles, next op accepted when out_ready rises.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mreq = mk(1'b0, 1'b0, 1'b1, 5'd3, 32'h11, 32'h0, 32'h0);
    tick();
    mreq = mk(1'b0, 1'b0, 1'b1, 5'd4, 32'h22, 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      check_bit($sformatf("bp in_ready c%0d", c), in_ready, 1'b0);
      check_bit($sformatf("bp out_valid c%0d", c), out_valid, 1'b1);
      check($sformatf("bp data c%0d", c), wb_require.write_data, 32'h11);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_bit("bp release in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check_bit("bp next out_valid", out_valid, 1'b1);
    check("bp next data", wb_require.write_data, 32'h22);
    check("bp next rd", 32'(wb_require.write_reg_addr), 32'd4);
    tick();
    check_bit("bp drained", out_valid, 1'b0);

    // Reset while waiting for load data; a late response must be ignored.
    in_valid = 1'b1;
    mreq = mk(1'b1, 1'b0, 1'b1, 5'd8, 32'h0, 32'h0, 32'h0000_0040);
    tick();
    in_valid = 1'b0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check_bit("rw in wait", dmem_req, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_bit("rw out_valid", out_valid, 1'b0);
    check_bit("rw dmem_req", dmem_req, 1'b0);
    check_bit("rw in_ready", in_ready, 1'b1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
    tick();
    dmem_rvalid = 1'b0;
    check_bit("rw late rvalid out_valid", out_valid, 1'b0);
    tick();
    check_bit("rw settled out_valid", out_valid, 1'b0);
    check_bit("rw settled dmem_req", dmem_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
